// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the pipelined CPU hazard logic.
//   shadow_entry_t : one in-flight destination record {valid, dst, wr, load}
//   sel_width()    : width of a forwarding select for a given tracked depth
//   FWD_REGFILE    : forwarding select value meaning "read the register file"
package cpu_pipe_pkg;

  // Shadow entries carry the destination index at this fixed width so the
  // struct can live in the package; register indices up to 8 bits fit.
  localparam int unsigned MAX_REG_INDEX_BITS = 8;

  typedef logic [MAX_REG_INDEX_BITS-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t dst;
    logic     wr;
    logic     load;
  } shadow_entry_t;

  localparam int unsigned FWD_REGFILE = 0;

  // Select values 0..depth need clog2(depth+1) bits.
  function automatic int unsigned sel_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one decode source operand against the shadow pipeline.
//   src_index/src_used : the source operand and whether it is actually read
//   shadow             : in-flight entries, index 1 = EXE (youngest)
//   match_idx          : smallest stage k holding a matching writer, 0 if none
//   match_load         : that youngest matching writer is a load
module hazard_match
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned REG_INDEX_BIT_WIDTH = 4,
  parameter int unsigned PIPE_DEPTH          = 3,
  parameter int unsigned SELW                = 2
) (
  input  logic [REG_INDEX_BIT_WIDTH-1:0] src_index,
  input  logic                           src_used,
  input  shadow_entry_t [PIPE_DEPTH:1]   shadow,
  output logic [SELW-1:0]                match_idx,
  output logic                           match_load
);

  logic found;

  always_comb begin
    match_idx  = '0;
    match_load = 1'b0;
    found      = 1'b0;
    for (int unsigned k = 1; k <= PIPE_DEPTH; k++) begin
      if (!found && src_used && shadow[k].valid && shadow[k].wr &&
          shadow[k].dst == reg_idx_t'(src_index)) begin
        found      = 1'b1;
        match_idx  = SELW'(k);
        match_load = shadow[k].load;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard controller: keeps a shadow pipeline of in-flight destinations and
// derives stall, flush and operand-forwarding selects, plus event counters.
//   clk, reset                : clock, synchronous active-high reset
//   dec_valid                 : decode holds a real instruction
//   src1/2_index, src1/2_used : decode source operands
//   dst_index, reg_wrt_en     : decode destination and write enable
//   is_load                   : decode instruction is a load
//   br_taken                  : EXE redirects the PC
//   stall, flush              : pipeline control (combinational)
//   fwd_sel1, fwd_sel2        : 0 = regfile, k = stage-k result
//   stall_count, flush_count  : wrapping event counters
module pipeline_hazard_unit
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned REG_INDEX_BIT_WIDTH = 4,
  parameter int unsigned PIPE_DEPTH          = 3,
  parameter int unsigned LOAD_READY_STAGE    = 2,
  parameter int unsigned FORWARDING          = 1,
  parameter int unsigned CNT_BITS            = 32,
  localparam int unsigned SELW               = sel_width(PIPE_DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dec_valid,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] src1_index,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] src2_index,
  input  logic                           src1_used,
  input  logic                           src2_used,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dst_index,
  input  logic                           reg_wrt_en,
  input  logic                           is_load,
  input  logic                           br_taken,
  output logic                           stall,
  output logic                           flush,
  output logic [SELW-1:0]                fwd_sel1,
  output logic [SELW-1:0]                fwd_sel2,
  output logic [CNT_BITS-1:0]            stall_count,
  output logic [CNT_BITS-1:0]            flush_count
);

  localparam logic [SELW-1:0] LOAD_READY = SELW'(LOAD_READY_STAGE);
  localparam logic [SELW-1:0] SEL_RF     = SELW'(FWD_REGFILE);

  shadow_entry_t [PIPE_DEPTH:1] shadow;

  logic [SELW-1:0] match_idx1, match_idx2;
  logic            match_load1, match_load2;
  logic            haz1, haz2;
  logic            load_use1, load_use2;
  logic            accept;

  hazard_match #(
    .REG_INDEX_BIT_WIDTH(REG_INDEX_BIT_WIDTH),
    .PIPE_DEPTH         (PIPE_DEPTH),
    .SELW               (SELW)
  ) u_match1 (
    .src_index (src1_index),
    .src_used  (src1_used),
    .shadow    (shadow),
    .match_idx (match_idx1),
    .match_load(match_load1)
  );

  hazard_match #(
    .REG_INDEX_BIT_WIDTH(REG_INDEX_BIT_WIDTH),
    .PIPE_DEPTH         (PIPE_DEPTH),
    .SELW               (SELW)
  ) u_match2 (
    .src_index (src2_index),
    .src_used  (src2_used),
    .shadow    (shadow),
    .match_idx (match_idx2),
    .match_load(match_load2)
  );

  // Only the youngest match matters: an older load behind a younger ALU
  // writer of the same register is shadowed and never causes a stall.
  always_comb begin
    load_use1 = (match_idx1 != SEL_RF) && match_load1 && (match_idx1 < LOAD_READY);
    load_use2 = (match_idx2 != SEL_RF) && match_load2 && (match_idx2 < LOAD_READY);
    if (FORWARDING != 0) begin
      haz1     = load_use1;
      haz2     = load_use2;
      fwd_sel1 = load_use1 ? SEL_RF : match_idx1;
      fwd_sel2 = load_use2 ? SEL_RF : match_idx2;
    end else begin
      haz1     = (match_idx1 != SEL_RF);
      haz2     = (match_idx2 != SEL_RF);
      fwd_sel1 = SEL_RF;
      fwd_sel2 = SEL_RF;
    end
  end

  assign flush  = br_taken;
  assign stall  = dec_valid && (haz1 || haz2) && !br_taken;
  assign accept = dec_valid && !stall && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
    end else begin
      shadow[1].valid <= accept;
      shadow[1].dst   <= accept ? reg_idx_t'(dst_index) : '0;
      shadow[1].wr    <= accept && reg_wrt_en;
      shadow[1].load  <= accept && is_load;
      for (int unsigned k = 2; k <= PIPE_DEPTH; k++) begin
        shadow[k] <= shadow[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall) stall_count <= stall_count + CNT_BITS'(1);
      if (flush) flush_count <= flush_count + CNT_BITS'(1);
    end
  end

endmodule
